csr_exec_unit: RTL and testbench

- Sequencer between the decode/execute pipeline and the CSR register file.
- Accepts one CSR-class instruction at a time (CSRRW/S/C, CSRRWI/SI/CI, ECALL, MRET) and performs the read-modify-write against the CSR file.
- Drives the CSR file's read address, write port, ecall/mret controls and write-valid strobe.
- Returns the rd writeback value, or a PC redirect, to the downstream writeback stage over a valid/ready handshake.

---
 rtl/csr_exec_unit_if.sv | 52 +++++
 rtl/csr_exec_unit.sv | 133 +++++++++++++
 tb/tb_csr_exec_unit.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_exec_unit_if.sv
// Bundle of the pipeline-side handshakes and the CSR-file port of csr_exec_unit.
// slave is the unit's view; master is the surrounding pipeline / CSR file.
interface csr_exec_unit_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CSR_AW     = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_pc;
    logic [2:0]            in_funct3;
    logic [CSR_AW-1:0]     in_csr_addr;
    logic [4:0]            in_rs1_idx;
    logic [DATA_WIDTH-1:0] in_rs1_val;
    logic [4:0]            in_rd_idx;
    logic                  in_ecall;
    logic                  in_mret;

    logic [CSR_AW-1:0]     csr_raddr;
    logic [DATA_WIDTH-1:0] csr_rdata;
    logic [CSR_AW-1:0]     csr_waddr;
    logic [DATA_WIDTH-1:0] csr_wdata;
    logic                  csr_wen;
    logic                  csr_ecall;
    logic                  csr_mret;
    logic [DATA_WIDTH-1:0] csr_pc;
    logic                  csr_wvalid;

    logic                  out_valid;
    logic                  out_ready;
    logic [4:0]            out_rd_idx;
    logic [DATA_WIDTH-1:0] out_rd_data;
    logic                  out_rd_we;
    logic                  out_redirect;
    logic [DATA_WIDTH-1:0] out_redirect_pc;
    logic                  out_illegal;

    modport slave (
        input  in_valid, in_pc, in_funct3, in_csr_addr, in_rs1_idx, in_rs1_val, in_rd_idx,
               in_ecall, in_mret, csr_rdata, out_ready,
        output in_ready, csr_raddr, csr_waddr, csr_wdata, csr_wen, csr_ecall, csr_mret, csr_pc,
               csr_wvalid, out_valid, out_rd_idx, out_rd_data, out_rd_we, out_redirect,
               out_redirect_pc, out_illegal
    );

    modport master (
        output in_valid, in_pc, in_funct3, in_csr_addr, in_rs1_idx, in_rs1_val, in_rd_idx,
               in_ecall, in_mret, csr_rdata, out_ready,
        input  in_ready, csr_raddr, csr_waddr, csr_wdata, csr_wen, csr_ecall, csr_mret, csr_pc,
               csr_wvalid, out_valid, out_rd_idx, out_rd_data, out_rd_we, out_redirect,
               out_redirect_pc, out_illegal
    );
endinterface

// File: rtl/csr_exec_unit.sv
// CSR instruction sequencer: latch, read CSR, commit read-modify-write, then hand the
// rd value or a PC redirect to writeback.
module csr_exec_unit #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CSR_AW      = 10,
    parameter int unsigned ECALL_CAUSE = 11
) (
    input logic             clk,
    input logic             rst,
    csr_exec_unit_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, rs1_val_q, old_q;
    logic [2:0]            funct3_q;
    logic [CSR_AW-1:0]     addr_q;
    logic [4:0]            rs1_idx_q, rd_idx_q;
    logic                  ecall_q, mret_q, illegal_q;

    logic                  accept, illegal_in;
    logic [DATA_WIDTH-1:0] src;

    assign accept     = bus.in_valid && bus.in_ready;
    assign illegal_in = !bus.in_ecall && !bus.in_mret && (bus.in_funct3[1:0] == 2'b00);
    assign src        = funct3_q[2] ? DATA_WIDTH'(rs1_idx_q) : rs1_val_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            rs1_val_q <= '0;
            old_q     <= '0;
            funct3_q  <= '0;
            addr_q    <= '0;
            rs1_idx_q <= '0;
            rd_idx_q  <= '0;
            ecall_q   <= 1'b0;
            mret_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pc_q      <= bus.in_pc;
                rs1_val_q <= bus.in_rs1_val;
                funct3_q  <= bus.in_funct3;
                addr_q    <= bus.in_csr_addr;
                rs1_idx_q <= bus.in_rs1_idx;
                rd_idx_q  <= bus.in_rd_idx;
                ecall_q   <= bus.in_ecall;
                // ECALL wins when both flags are set
                mret_q    <= bus.in_mret && !bus.in_ecall;
                illegal_q <= illegal_in;
            end
            if (state_q == StRead) old_q <= bus.csr_rdata;
        end
    end

    always_comb begin
        state_d             = state_q;
        bus.in_ready        = 1'b0;
        bus.csr_raddr       = '0;
        bus.csr_waddr       = '0;
        bus.csr_wdata       = '0;
        bus.csr_wen         = 1'b0;
        bus.csr_ecall       = 1'b0;
        bus.csr_mret        = 1'b0;
        bus.csr_pc          = '0;
        bus.csr_wvalid      = 1'b0;
        bus.out_valid       = 1'b0;
        bus.out_rd_idx      = '0;
        bus.out_rd_data     = '0;
        bus.out_rd_we       = 1'b0;
        bus.out_redirect    = 1'b0;
        bus.out_redirect_pc = '0;
        bus.out_illegal     = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.in_ready = !rst;
                if (accept) state_d = illegal_in ? StResp : StRead;
            end
            StRead: begin
                bus.csr_raddr = addr_q;
                bus.csr_ecall = ecall_q;
                bus.csr_mret  = mret_q;
                state_d       = StWrite;
            end
            StWrite: begin
                bus.csr_wvalid = 1'b1;
                bus.csr_ecall  = ecall_q;
                bus.csr_mret   = mret_q;
                bus.csr_waddr  = addr_q;
                bus.csr_pc     = pc_q;
                if (ecall_q) begin
                    bus.csr_wdata = DATA_WIDTH'(ECALL_CAUSE);
                end else if (!mret_q) begin
                    unique case (funct3_q[1:0])
                        2'b01: begin
                            bus.csr_wen   = 1'b1;
                            bus.csr_wdata = src;
                        end
                        2'b10: begin
                            bus.csr_wen   = (rs1_idx_q != 5'd0);
                            bus.csr_wdata = old_q | src;
                        end
                        2'b11: begin
                            bus.csr_wen   = (rs1_idx_q != 5'd0);
                            bus.csr_wdata = old_q & ~src;
                        end
                        default: ;
                    endcase
                end
                state_d = StResp;
            end
            StResp: begin
                bus.out_valid  = 1'b1;
                bus.out_rd_idx = rd_idx_q;
                if (illegal_q) begin
                    bus.out_illegal = 1'b1;
                end else if (ecall_q || mret_q) begin
                    bus.out_redirect    = 1'b1;
                    bus.out_redirect_pc = old_q;
                end else begin
                    bus.out_rd_data = old_q;
                    bus.out_rd_we   = (rd_idx_q != 5'd0);
                end
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end
endmodule

// File: tb/tb_csr_exec_unit.sv
// Scoreboard bench for csr_exec_unit: a CSR-file model, a reference model of the
// instruction semantics, and monitors for the commit strobe and the result port.
module tb_csr_exec_unit;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam logic [AW-1:0] MSTATUS = 10'h300;
    localparam logic [AW-1:0] MTVEC   = 10'h305;
    localparam logic [AW-1:0] MSCR    = 10'h340;
    localparam logic [AW-1:0] MEPC    = 10'h341;
    localparam logic [AW-1:0] MCAUSE  = 10'h342;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csr_exec_unit_if #(.DATA_WIDTH(DW), .CSR_AW(AW)) bus ();

    csr_exec_unit #(.DATA_WIDTH(DW), .CSR_AW(AW), .ECALL_CAUSE(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          wen;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          ecall;
        logic          mret;
        logic [DW-1:0] pc;
    } wr_t;

    typedef struct {
        logic [4:0]    rd_idx;
        logic [DW-1:0] rd_data;
        logic          rd_we;
        logic          redirect;
        logic [DW-1:0] redirect_pc;
        logic          illegal;
    } resp_t;

    wr_t   wq[$];
    resp_t rq[$];
    int    aq[$];

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;
    int ready_mode = 0;

    logic [DW-1:0] csr_mem [1024];
    logic [DW-1:0] ref_csr [1024];
    logic          mem_clr = 1'b0;
    logic          pre_we  = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // CSR file: combinational read, commit on the strobe
    assign bus.csr_rdata = bus.csr_ecall ? csr_mem[MTVEC] :
                           bus.csr_mret  ? csr_mem[MEPC]  : csr_mem[bus.csr_raddr];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) csr_mem[i] <= '0;
        end else if (pre_we) begin
            csr_mem[pre_addr] <= pre_data;
        end else if (!rst && bus.csr_wvalid) begin
            if (bus.csr_wen) csr_mem[bus.csr_waddr] <= bus.csr_wdata;
            if (bus.csr_ecall) begin
                csr_mem[MCAUSE] <= bus.csr_wdata;
                csr_mem[MEPC]   <= bus.csr_pc;
            end
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: commit strobe and result port
    resp_t         cur;
    logic          pend = 1'b0;
    logic [DW-1:0] hold_data, hold_pc;
    logic [7:0]    hold_flags;

    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (bus.csr_wvalid) begin
                if (wq.size() == 0) begin
                    chk("unexpected_wvalid", 64'(bus.csr_wvalid), 64'd0);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("csr_wen",   64'(bus.csr_wen),   64'(w.wen));
                    chk("csr_waddr", 64'(bus.csr_waddr), 64'(w.waddr));
                    chk("csr_wdata", 64'(bus.csr_wdata), 64'(w.wdata));
                    chk("csr_ecall", 64'(bus.csr_ecall), 64'(w.ecall));
                    chk("csr_mret",  64'(bus.csr_mret),  64'(w.mret));
                    chk("csr_pc",    64'(bus.csr_pc),    64'(w.pc));
                end
            end
            if (bus.out_valid) begin
                chk("in_ready_in_resp", 64'(bus.in_ready), 64'd0);
                if (!pend) begin
                    if (rq.size() == 0 || aq.size() == 0) begin
                        chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
                    end else begin
                        int lat;
                        cur = rq.pop_front();
                        lat = edge_cnt - aq.pop_front() + 1;
                        chk("latency", 64'(lat), cur.illegal ? 64'd1 : 64'd3);
                        chk("out_rd_idx",   64'(bus.out_rd_idx),   64'(cur.rd_idx));
                        chk("out_rd_we",    64'(bus.out_rd_we),    64'(cur.rd_we));
                        chk("out_redirect", 64'(bus.out_redirect), 64'(cur.redirect));
                        chk("out_illegal",  64'(bus.out_illegal),  64'(cur.illegal));
                        if (cur.redirect)
                            chk("out_redirect_pc", 64'(bus.out_redirect_pc),
                                64'(cur.redirect_pc));
                        else if (!cur.illegal)
                            chk("out_rd_data", 64'(bus.out_rd_data), 64'(cur.rd_data));
                    end
                    pend = 1'b1;
                end else begin
                    chk("hold_data", 64'(bus.out_rd_data), 64'(hold_data));
                    chk("hold_pc",   64'(bus.out_redirect_pc), 64'(hold_pc));
                    chk("hold_flags", 64'({bus.out_rd_idx, bus.out_rd_we, bus.out_redirect,
                                           bus.out_illegal}), 64'(hold_flags));
                end
                hold_data  = bus.out_rd_data;
                hold_pc    = bus.out_redirect_pc;
                hold_flags = {bus.out_rd_idx, bus.out_rd_we, bus.out_redirect, bus.out_illegal};
                if (bus.out_ready) pend = 1'b0;
            end
        end
    end

    // Reference model of one instruction; updates ref_csr and queues expectations
    task automatic model(input logic [2:0] f3, input logic [AW-1:0] a, input logic [4:0] ri,
                         input logic [DW-1:0] rv, input logic [4:0] rd, input logic ec,
                         input logic mr, input logic [DW-1:0] pc);
        wr_t w;
        resp_t r;
        logic [DW-1:0] old, srcv, nv;
        r.rd_idx = rd; r.rd_data = '0; r.rd_we = 1'b0;
        r.redirect = 1'b0; r.redirect_pc = '0; r.illegal = 1'b0;
        w.waddr = a; w.pc = pc; w.ecall = 1'b0; w.mret = 1'b0; w.wen = 1'b0; w.wdata = '0;
        if (ec) begin
            w.ecall = 1'b1; w.wdata = 32'd11;
            r.redirect = 1'b1; r.redirect_pc = ref_csr[MTVEC];
            ref_csr[MCAUSE] = 32'd11;
            ref_csr[MEPC] = pc;
            wq.push_back(w);
        end else if (mr) begin
            w.mret = 1'b1;
            r.redirect = 1'b1; r.redirect_pc = ref_csr[MEPC];
            wq.push_back(w);
        end else if (f3 == 3'd0 || f3 == 3'd4) begin
            r.illegal = 1'b1;
        end else begin
            old  = ref_csr[a];
            srcv = f3[2] ? {27'd0, ri} : rv;
            case (f3 & 3'd3)
                3'd1:    begin nv = srcv;         w.wen = 1'b1;       end
                3'd2:    begin nv = old | srcv;   w.wen = (ri != 0);  end
                default: begin nv = old & ~srcv;  w.wen = (ri != 0);  end
            endcase
            w.wdata = nv;
            if (w.wen) ref_csr[a] = nv;
            r.rd_data = old;
            r.rd_we = (rd != 0);
            wq.push_back(w);
        end
        rq.push_back(r);
    endtask

    task automatic issue(input logic [2:0] f3, input logic [AW-1:0] a, input logic [4:0] ri,
                         input logic [DW-1:0] rv, input logic [4:0] rd, input logic ec,
                         input logic mr, input logic [DW-1:0] pc, input bit expect_it);
        int n = 0;
        @(negedge clk);
        bus.in_funct3 = f3; bus.in_csr_addr = a; bus.in_rs1_idx = ri; bus.in_rs1_val = rv;
        bus.in_rd_idx = rd; bus.in_ecall = ec; bus.in_mret = mr; bus.in_pc = pc;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 64'd1, 64'd0);
        if (expect_it) model(f3, a, ri, rv, rd, ec, mr, pc);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (expect_it) aq.push_back(edge_cnt);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        ref_csr[a] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || wq.size() != 0 || pend) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    localparam logic [AW-1:0] ADDRS [6] = '{MSTATUS, MTVEC, MSCR, MEPC, MCAUSE, 10'h000};

    initial begin
        int n;
        bus.in_valid = 1'b0; bus.in_funct3 = '0; bus.in_csr_addr = '0; bus.in_rs1_idx = '0;
        bus.in_rs1_val = '0; bus.in_rd_idx = '0; bus.in_ecall = 1'b0; bus.in_mret = 1'b0;
        bus.in_pc = '0;
        for (int i = 0; i < 1024; i++) ref_csr[i] = '0;
        rst = 1'b1; mem_clr = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_csr_outs", 64'({bus.csr_wvalid, bus.csr_wen, bus.csr_ecall, bus.csr_mret,
                                 bus.csr_wdata}), 64'd0);
        rst = 1'b0; mem_clr = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

        preload(MSTATUS, 32'h0000_1800);
        issue(3'b001, MTVEC, 5'd5, 32'h8000_0100, 5'd7, 1'b0, 1'b0, 32'h8000_0000, 1'b1);
        drain();
        chk("mtvec_written", 64'(csr_mem[MTVEC]), 64'h8000_0100);
        issue(3'b010, MSTATUS, 5'd0, 32'h0, 5'd3, 1'b0, 1'b0, 32'h8000_0004, 1'b1);
        issue(3'b110, MSTATUS, 5'd3, 32'h0, 5'd4, 1'b0, 1'b0, 32'h8000_0008, 1'b1);
        issue(3'b001, MTVEC, 5'd6, 32'h8000_0200, 5'd0, 1'b0, 1'b0, 32'h8000_000c, 1'b1);
        issue(3'b000, 10'h000, 5'd0, 32'h0, 5'd0, 1'b1, 1'b0, 32'h8000_0040, 1'b1);
        drain();
        chk("mstatus_rsi", 64'(csr_mem[MSTATUS]), 64'h1803);
        chk("mepc_ecall", 64'(csr_mem[MEPC]), 64'h8000_0040);
        chk("mcause_ecall", 64'(csr_mem[MCAUSE]), 64'd11);
        preload(MEPC, 32'h8000_0044);
        issue(3'b000, 10'h302, 5'd0, 32'h0, 5'd0, 1'b0, 1'b1, 32'h8000_0300, 1'b1);
        issue(3'b000, 10'h000, 5'd0, 32'h0, 5'd0, 1'b1, 1'b1, 32'h8000_0050, 1'b1);
        drain();

        ready_mode = 2;
        issue(3'b001, MSCR, 5'd9, 32'hdead_beef, 5'd12, 1'b0, 1'b0, 32'h8000_0060, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", 64'(bus.out_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        end
        ready_mode = 0;
        drain();
        issue(3'b100, MSTATUS, 5'd1, 32'h1, 5'd2, 1'b0, 1'b0, 32'h8000_0070, 1'b1);
        drain();

        // Reset while the commit strobe is up
        issue(3'b001, MSCR, 5'd1, 32'h1234_5678, 5'd1, 1'b0, 1'b0, 32'h8000_0080, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_wvalid", 64'(bus.csr_wvalid), 64'd0);
        chk("abort_outs", 64'({bus.out_valid, bus.in_ready, bus.csr_wen, bus.csr_wdata}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_write", 64'(csr_mem[MSCR]), 64'(ref_csr[MSCR]));
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        issue(3'b011, MSTATUS, 5'd8, 32'h0000_0800, 5'd10, 1'b0, 1'b0, 32'h8000_0090, 1'b1);
        drain();
        chk("mstatus_rc", 64'(csr_mem[MSTATUS]), 64'h1003);

        ready_mode = 1;
        for (int k = 0; k < 150; k++) begin
            int kind;
            logic [2:0] f3;
            logic [AW-1:0] a;
            logic [4:0] ri;
            kind = $urandom_range(11);
            a = ($urandom_range(4) == 0) ? AW'($urandom) : ADDRS[$urandom_range(5)];
            ri = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
            f3 = 3'($urandom_range(1, 3)) | ($urandom_range(1) ? 3'd4 : 3'd0);
            if (kind == 0)
                issue(3'($urandom), a, ri, $urandom, 5'($urandom), 1'b1, 1'($urandom),
                      $urandom, 1'b1);
            else if (kind == 1)
                issue(3'($urandom), a, ri, $urandom, 5'($urandom), 1'b0, 1'b1, $urandom, 1'b1);
            else if (kind == 2)
                issue($urandom_range(1) ? 3'd4 : 3'd0, a, ri, $urandom, 5'($urandom), 1'b0,
                      1'b0, $urandom, 1'b1);
            else
                issue(f3, a, ri, $urandom, 5'($urandom), 1'b0, 1'b0, $urandom, 1'b1);
        end
        ready_mode = 0;
        drain();
        chk("final_mstatus", 64'(csr_mem[MSTATUS]), 64'(ref_csr[MSTATUS]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
